mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates instruction read, data read and data write ports onto one memory bus
// Fixed priority write > data read > instruction read; one bus transaction at a time with ACK timeout.
module mem_arbiter #(
  parameter int TIMEOUT = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INST_RDEN,
  input  logic [31:0] INST_RIADDR,
  output logic [31:0] INST_ROADDR,
  output logic        INST_RVALID,
  output logic [31:0] INST_RDATA,
  input  logic        DATA_RDEN,
  input  logic [31:0] DATA_RIADDR,
  output logic [31:0] DATA_ROADDR,
  output logic        DATA_RVALID,
  output logic [31:0] DATA_RDATA,
  input  logic        DATA_WREN,
  input  logic [31:0] DATA_WADDR,
  input  logic [3:0]  DATA_WSTRB,
  input  logic [31:0] DATA_WDATA,
  output logic        MEM_WAIT,
  output logic        BUS_REQ,
  output logic        BUS_WE,
  output logic [31:0] BUS_ADDR,
  output logic [3:0]  BUS_STRB,
  output logic [31:0] BUS_WDATA,
  input  logic        BUS_ACK,
  input  logic [31:0] BUS_RDATA,
  output logic        BUS_ERR
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] SEL_INST = 2'd0;
  localparam logic [1:0] SEL_DRD  = 2'd1;
  localparam logic [1:0] SEL_WR   = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_WAIT, S_DONE} state_t;

  state_t        state_q;
  logic [2:0]    pend_q;
  logic          inst_done_q, data_done_q;
  logic [1:0]    sel_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   inst_addr_q, drd_addr_q, wr_addr_q, wr_data_q;
  logic [3:0]    wr_strb_q;
  logic [31:0]   inst_rdata_q, inst_roaddr_q, data_rdata_q, data_roaddr_q;
  logic          bus_err_q;

  logic [1:0]    pick;
  logic [1:0]    cur_sel;
  logic          bus_active;
  logic          complete;
  logic [31:0]   rd_data_d;

  always_comb begin
    pick = SEL_INST;
    if (pend_q[2])      pick = SEL_WR;
    else if (pend_q[1]) pick = SEL_DRD;
  end

  // In ARB the selection is still combinational; WAIT holds the registered choice.
  assign cur_sel    = (state_q == S_ARB) ? pick : sel_q;
  assign bus_active = (state_q == S_ARB) || (state_q == S_WAIT);
  assign complete   = BUS_ACK || (cnt_q == CW'(TIMEOUT - 1));
  assign rd_data_d  = BUS_ACK ? BUS_RDATA : 32'h0;

  assign MEM_WAIT  = bus_active;
  assign BUS_REQ   = (state_q == S_ARB);
  assign BUS_WE    = bus_active && (cur_sel == SEL_WR);
  assign BUS_STRB  = !bus_active ? 4'h0 : (BUS_WE ? wr_strb_q : 4'hF);
  assign BUS_WDATA = BUS_WE ? wr_data_q : 32'h0;

  always_comb begin
    BUS_ADDR = 32'h0;
    if (bus_active) begin
      case (cur_sel)
        SEL_WR:  BUS_ADDR = wr_addr_q;
        SEL_DRD: BUS_ADDR = drd_addr_q;
        default: BUS_ADDR = inst_addr_q;
      endcase
    end
  end

  assign INST_RVALID = (state_q == S_DONE) && inst_done_q;
  assign DATA_RVALID = (state_q == S_DONE) && data_done_q;
  assign INST_RDATA  = inst_rdata_q;
  assign INST_ROADDR = inst_roaddr_q;
  assign DATA_RDATA  = data_rdata_q;
  assign DATA_ROADDR = data_roaddr_q;
  assign BUS_ERR     = bus_err_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= S_IDLE;
      pend_q        <= 3'b000;
      inst_done_q   <= 1'b0;
      data_done_q   <= 1'b0;
      sel_q         <= SEL_INST;
      cnt_q         <= '0;
      inst_addr_q   <= 32'h0;
      drd_addr_q    <= 32'h0;
      wr_addr_q     <= 32'h0;
      wr_data_q     <= 32'h0;
      wr_strb_q     <= 4'h0;
      inst_rdata_q  <= 32'h0;
      inst_roaddr_q <= 32'h0;
      data_rdata_q  <= 32'h0;
      data_roaddr_q <= 32'h0;
      bus_err_q     <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          inst_done_q <= 1'b0;
          data_done_q <= 1'b0;
          pend_q      <= pend_q | {DATA_WREN, DATA_RDEN, INST_RDEN};
          if (INST_RDEN) inst_addr_q <= INST_RIADDR;
          if (DATA_RDEN) drd_addr_q  <= DATA_RIADDR;
          if (DATA_WREN) begin
            wr_addr_q <= DATA_WADDR;
            wr_strb_q <= DATA_WSTRB;
            wr_data_q <= DATA_WDATA;
          end
          state_q <= (INST_RDEN || DATA_RDEN || DATA_WREN) ? S_ARB : S_IDLE;
        end
        S_ARB: begin
          sel_q        <= pick;
          pend_q[pick] <= 1'b0;
          cnt_q        <= '0;
          state_q      <= S_WAIT;
        end
        S_WAIT: begin
          if (complete) begin
            // A timeout completes like an ACK carrying zero data, flagged one cycle later.
            bus_err_q <= !BUS_ACK;
            if (sel_q == SEL_INST) begin
              inst_rdata_q  <= rd_data_d;
              inst_roaddr_q <= inst_addr_q;
              inst_done_q   <= 1'b1;
            end else if (sel_q == SEL_DRD) begin
              data_rdata_q  <= rd_data_d;
              data_roaddr_q <= drd_addr_q;
              data_done_q   <= 1'b1;
            end
            state_q <= (pend_q != 3'b000) ? S_ARB : S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        INST_RDEN = 1'b0;
  logic [31:0] INST_RIADDR = 32'h0;
  logic [31:0] INST_ROADDR;
  logic        INST_RVALID;
  logic [31:0] INST_RDATA;
  logic        DATA_RDEN = 1'b0;
  logic [31:0] DATA_RIADDR = 32'h0;
  logic [31:0] DATA_ROADDR;
  logic        DATA_RVALID;
  logic [31:0] DATA_RDATA;
  logic        DATA_WREN = 1'b0;
  logic [31:0] DATA_WADDR = 32'h0;
  logic [3:0]  DATA_WSTRB = 4'h0;
  logic [31:0] DATA_WDATA = 32'h0;
  logic        MEM_WAIT;
  logic        BUS_REQ;
  logic        BUS_WE;
  logic [31:0] BUS_ADDR;
  logic [3:0]  BUS_STRB;
  logic [31:0] BUS_WDATA;
  logic        BUS_ACK = 1'b0;
  logic [31:0] BUS_RDATA = 32'h0;
  logic        BUS_ERR;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR),
    .INST_ROADDR(INST_ROADDR), .INST_RVALID(INST_RVALID), .INST_RDATA(INST_RDATA),
    .DATA_RDEN(DATA_RDEN), .DATA_RIADDR(DATA_RIADDR),
    .DATA_ROADDR(DATA_ROADDR), .DATA_RVALID(DATA_RVALID), .DATA_RDATA(DATA_RDATA),
    .DATA_WREN(DATA_WREN), .DATA_WADDR(DATA_WADDR), .DATA_WSTRB(DATA_WSTRB),
    .DATA_WDATA(DATA_WDATA), .MEM_WAIT(MEM_WAIT),
    .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR), .BUS_STRB(BUS_STRB),
    .BUS_WDATA(BUS_WDATA), .BUS_ACK(BUS_ACK), .BUS_RDATA(BUS_RDATA), .BUS_ERR(BUS_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge CLK);
  endtask

  // Wait (bounded) for BUS_REQ, check the request, then ACK it in the following WAIT cycle.
  task automatic serve(input string tag, input logic we, input logic [31:0] addr,
                       input logic [3:0] strb, input logic [31:0] wdata, input logic [31:0] rdata);
    int k;
    k = 0;
    while (!BUS_REQ && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_req"}, 32'(BUS_REQ), 32'd1);
    check({tag, "_we"}, 32'(BUS_WE), 32'(we));
    check({tag, "_addr"}, BUS_ADDR, addr);
    check({tag, "_strb"}, 32'(BUS_STRB), 32'(strb));
    check({tag, "_wdata"}, BUS_WDATA, wdata);
    tick();
    check({tag, "_wait_req"}, 32'(BUS_REQ), 32'd0);
    check({tag, "_wait_addr"}, BUS_ADDR, addr);
    BUS_ACK = 1'b1;
    BUS_RDATA = rdata;
    tick();
    BUS_ACK = 1'b0;
    BUS_RDATA = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    check("rst_memwait", 32'(MEM_WAIT), 32'd0);
    check("rst_busreq", 32'(BUS_REQ), 32'd0);
    check("rst_busaddr", BUS_ADDR, 32'h0);
    check("rst_busstrb", 32'(BUS_STRB), 32'h0);
    check("rst_rvalid", 32'({INST_RVALID, DATA_RVALID, BUS_ERR}), 32'h0);
    check("rst_rdata", INST_RDATA | DATA_RDATA | INST_ROADDR | DATA_ROADDR, 32'h0);

    // Single instruction read, requested in the first cycle after reset release
    RST = 1'b1;
    INST_RDEN = 1'b1;
    INST_RIADDR = 32'h100;
    tick();
    INST_RDEN = 1'b0;
    check("t1_c1_memwait", 32'(MEM_WAIT), 32'd1);
    serve("t1", 1'b0, 32'h100, 4'hF, 32'h0, 32'h0000_0013);
    check("t1_c3_rvalid", 32'(INST_RVALID), 32'd1);
    check("t1_c3_roaddr", INST_ROADDR, 32'h100);
    check("t1_c3_rdata", INST_RDATA, 32'h13);
    check("t1_c3_memwait", 32'(MEM_WAIT), 32'd0);
    check("t1_c3_drvalid", 32'(DATA_RVALID), 32'd0);
    tick();
    check("t1_c4_rvalid", 32'(INST_RVALID), 32'd0);
    check("t1_c4_hold", INST_RDATA, 32'h13);

    // Three simultaneous requests: write, data read, instruction read
    DATA_WREN = 1'b1; DATA_WADDR = 32'h200; DATA_WSTRB = 4'b0011; DATA_WDATA = 32'hAABB;
    DATA_RDEN = 1'b1; DATA_RIADDR = 32'h204;
    INST_RDEN = 1'b1; INST_RIADDR = 32'h108;
    tick();
    DATA_WREN = 1'b0; DATA_RDEN = 1'b0; INST_RDEN = 1'b0;
    serve("t2w", 1'b1, 32'h200, 4'b0011, 32'hAABB, 32'hDEAD_BEEF);
    check("t2w_norvalid", 32'({INST_RVALID, DATA_RVALID}), 32'h0);
    check("t2w_memwait", 32'(MEM_WAIT), 32'd1);
    serve("t2d", 1'b0, 32'h204, 4'hF, 32'h0, 32'h1111_2222);
    check("t2d_norvalid", 32'({INST_RVALID, DATA_RVALID}), 32'h0);
    serve("t2i", 1'b0, 32'h108, 4'hF, 32'h0, 32'h3333_4444);
    check("t2_rvalids", 32'({INST_RVALID, DATA_RVALID}), 32'h3);
    check("t2_drdata", DATA_RDATA, 32'h1111_2222);
    check("t2_droaddr", DATA_ROADDR, 32'h204);
    check("t2_irdata", INST_RDATA, 32'h3333_4444);
    check("t2_iroaddr", INST_ROADDR, 32'h108);
    tick();
    check("t2_after_rvalids", 32'({INST_RVALID, DATA_RVALID}), 32'h0);

    // Timeout with TIMEOUT=4: four WAIT cycles then forced completion with zero data
    DATA_RDEN = 1'b1; DATA_RIADDR = 32'h300;
    tick();
    DATA_RDEN = 1'b0;
    check("t3_busreq", 32'(BUS_REQ), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_wait_memwait", 32'(MEM_WAIT), 32'd1);
      check("t3_wait_err", 32'(BUS_ERR), 32'd0);
    end
    tick();
    check("t3_err", 32'(BUS_ERR), 32'd1);
    check("t3_rvalid", 32'(DATA_RVALID), 32'd1);
    check("t3_rdata", DATA_RDATA, 32'h0);
    check("t3_roaddr", DATA_ROADDR, 32'h300);
    tick();
    check("t3_err_pulse", 32'(BUS_ERR), 32'd0);

    // Reset in WAIT, then a late ACK
    INST_RDEN = 1'b1; INST_RIADDR = 32'h400;
    tick();
    INST_RDEN = 1'b0;
    tick();
    check("t4_inwait", 32'(MEM_WAIT), 32'd1);
    RST = 1'b0;
    #1;
    check("t4_rst_memwait", 32'(MEM_WAIT), 32'd0);
    check("t4_rst_busaddr", BUS_ADDR, 32'h0);
    check("t4_rst_rdata", INST_RDATA | DATA_RDATA | INST_ROADDR | DATA_ROADDR, 32'h0);
    tick();
    RST = 1'b1;
    BUS_ACK = 1'b1; BUS_RDATA = 32'h5555;
    tick();
    BUS_ACK = 1'b0; BUS_RDATA = 32'h0;
    check("t4_ack_ignored", 32'({BUS_REQ, MEM_WAIT, INST_RVALID}), 32'h0);
    tick();
    check("t4_no_rvalid", 32'({INST_RVALID, DATA_RVALID}), 32'h0);
    check("t4_rdata", INST_RDATA, 32'h0);

    // Requests raised while MEM_WAIT is high are never issued
    INST_RDEN = 1'b1; INST_RIADDR = 32'h500;
    tick();
    INST_RDEN = 1'b0;
    DATA_RDEN = 1'b1; DATA_RIADDR = 32'h600;
    DATA_WREN = 1'b1; DATA_WADDR = 32'h604;
    tick();
    DATA_RDEN = 1'b0; DATA_WREN = 1'b0;
    BUS_ACK = 1'b1; BUS_RDATA = 32'h77;
    tick();
    BUS_ACK = 1'b0; BUS_RDATA = 32'h0;
    check("t5_irvalid", 32'(INST_RVALID), 32'd1);
    check("t5_drvalid", 32'(DATA_RVALID), 32'd0);
    check("t5_irdata", INST_RDATA, 32'h77);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no_busreq", 32'({BUS_REQ, MEM_WAIT}), 32'h0);
    end

    // New request accepted in the DONE cycle of a previous read
    INST_RDEN = 1'b1; INST_RIADDR = 32'h700;
    tick();
    INST_RDEN = 1'b0;
    serve("t6a", 1'b0, 32'h700, 4'hF, 32'h0, 32'h88);
    check("t6_done_rvalid", 32'(INST_RVALID), 32'd1);
    check("t6_done_rdata", INST_RDATA, 32'h88);
    INST_RDEN = 1'b1; INST_RIADDR = 32'h704;
    tick();
    INST_RDEN = 1'b0;
    check("t6_next_busreq", 32'(BUS_REQ), 32'd1);
    check("t6_next_addr", BUS_ADDR, 32'h704);
    check("t6_next_rvalid", 32'(INST_RVALID), 32'd0);
    check("t6_roaddr_hold", INST_ROADDR, 32'h700);
    serve("t6b", 1'b0, 32'h704, 4'hF, 32'h0, 32'h99);
    check("t6b_rvalid", 32'(INST_RVALID), 32'd1);
    check("t6b_rdata", INST_RDATA, 32'h99);
    check("t6b_roaddr", INST_ROADDR, 32'h704);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
